// File: rtl/delay_config_scheduler_pkg.sv
// Shared beamformer constants and the serial-config receiver state encoding.
package beamformer_pkg;

  localparam int NUMBER_OF_BITS = 16;
  localparam int BUFFER_SIZE    = 8;
  localparam int IDX_W          = $clog2(BUFFER_SIZE);
  localparam int CH_W           = 3;
  localparam int CMD_W          = CH_W + IDX_W;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_FULL,
    RX_OVER
  } rx_state_e;

endpackage

// File: rtl/delay_config_scheduler_if.sv
// Config pins in, active delays and status out, between MCU port and channel buffers.
interface delay_config_scheduler_if #(
  parameter int NUM_CHANNELS = 8,
  parameter int IDX_W        = beamformer_pkg::IDX_W
);
  logic                          cfg_sdata;
  logic                          cfg_shift;
  logic                          cfg_latch;
  logic                          frame_start;
  logic                          err_clear;
  logic [NUM_CHANNELS*IDX_W-1:0] read_index;
  logic                          pending;
  logic                          cfg_error;

  modport master (
    output cfg_sdata, cfg_shift, cfg_latch, frame_start, err_clear,
    input  read_index, pending, cfg_error
  );

  modport slave (
    input  cfg_sdata, cfg_shift, cfg_latch, frame_start, err_clear,
    output read_index, pending, cfg_error
  );
endinterface

// File: rtl/delay_config_scheduler_cfg_serial_rx.sv
// 3-wire command receiver: shift register, saturating bit counter and framing FSM.
module cfg_serial_rx #(
  parameter int NUM_CHANNELS = 8,
  parameter int CH_W         = 3,
  parameter int IDX_W        = 3,
  parameter int CMD_W        = CH_W + IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sdata,
  input  logic             shift,
  input  logic             latch,
  output logic             cmd_valid,
  output logic             cmd_error,
  output logic [CH_W-1:0]  cmd_channel,
  output logic [IDX_W-1:0] cmd_delay
);
  import beamformer_pkg::*;

  localparam int CNT_W = $clog2(CMD_W + 2);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CMD_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMD_W - 1);
  localparam logic [CH_W:0]    NCH      = (CH_W + 1)'(NUM_CHANNELS);

  rx_state_e        state_q, state_sh, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_sh, cnt_d;
  logic [CMD_W-1:0] sreg_q, sreg_sh;
  logic             ch_ok;

  // The shift is applied first; a same-cycle latch judges the post-shift state.
  always_comb begin
    sreg_sh  = sreg_q;
    cnt_sh   = cnt_q;
    state_sh = state_q;
    if (shift) begin
      sreg_sh = {sreg_q[CMD_W-2:0], sdata};
      if (cnt_q != CNT_SAT) cnt_sh = cnt_q + 1'b1;
      unique case (state_q)
        RX_IDLE:  state_sh = RX_SHIFT;
        RX_SHIFT: state_sh = (cnt_q == CNT_LAST) ? RX_FULL : RX_SHIFT;
        RX_FULL:  state_sh = RX_OVER;
        RX_OVER:  state_sh = RX_OVER;
        default:  state_sh = RX_IDLE;
      endcase
    end
    state_d = latch ? RX_IDLE : state_sh;
    cnt_d   = latch ? '0      : cnt_sh;
  end

  assign cmd_channel = sreg_sh[CMD_W-1:IDX_W];
  assign cmd_delay   = sreg_sh[IDX_W-1:0];
  assign ch_ok       = {1'b0, cmd_channel} < NCH;
  assign cmd_valid   = latch && (state_sh == RX_FULL) && ch_ok;
  assign cmd_error   = latch && !cmd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_sh;
    end
  end

endmodule

// File: rtl/delay_config_scheduler.sv
// Stages per-channel delay commands in shadow registers and applies them all on a frame boundary.
module delay_config_scheduler #(
  parameter int NUM_CHANNELS = 8,
  parameter int BUFFER_SIZE  = beamformer_pkg::BUFFER_SIZE,
  parameter int IDX_W        = $clog2(BUFFER_SIZE),
  parameter int CH_W         = beamformer_pkg::CH_W,
  parameter int CMD_W        = CH_W + IDX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  delay_config_scheduler_if.slave  bus
);
  import beamformer_pkg::*;

  logic [NUM_CHANNELS-1:0][IDX_W-1:0] shadow_q, shadow_d;
  logic [NUM_CHANNELS-1:0][IDX_W-1:0] active_q, active_d;
  logic [NUM_CHANNELS-1:0]            dirty_q, dirty_d;
  logic                               pending_q, pending_d;
  logic                               err_q, err_d;
  logic                               apply;
  logic                               cmd_valid, cmd_error;
  logic [CH_W-1:0]                    cmd_channel;
  logic [IDX_W-1:0]                   cmd_delay;

  cfg_serial_rx #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CH_W         (CH_W),
    .IDX_W        (IDX_W),
    .CMD_W        (CMD_W)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .sdata       (bus.cfg_sdata),
    .shift       (bus.cfg_shift),
    .latch       (bus.cfg_latch),
    .cmd_valid   (cmd_valid),
    .cmd_error   (cmd_error),
    .cmd_channel (cmd_channel),
    .cmd_delay   (cmd_delay)
  );

  assign apply = bus.frame_start && pending_q;

  // A frame copies the old shadow first; a same-cycle command re-dirties its channel for the next frame.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    dirty_d  = dirty_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (apply) begin
        if (dirty_q[i]) active_d[i] = shadow_q[i];
        dirty_d[i] = 1'b0;
      end
      if (cmd_valid && (cmd_channel == CH_W'(i))) begin
        shadow_d[i] = cmd_delay;
        dirty_d[i]  = 1'b1;
      end
    end
    pending_d = (pending_q && !bus.frame_start) || cmd_valid;
    err_d     = cmd_error || (err_q && !bus.err_clear);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      dirty_q   <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      dirty_q   <= dirty_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign bus.read_index = active_q;
  assign bus.pending    = pending_q;
  assign bus.cfg_error  = err_q;

endmodule

// File: tb/tb_delay_config_scheduler.sv
// Bench for delay_config_scheduler: vector table, frame scoreboard and reset/handshake corner sequences.
module tb_delay_config_scheduler;
  localparam int NC = 8;
  localparam int IW = 3;
  localparam int RW = NC * IW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  delay_config_scheduler_if #(.NUM_CHANNELS(NC), .IDX_W(IW)) bus ();

  delay_config_scheduler #(.NUM_CHANNELS(NC), .BUFFER_SIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string          name;
    int             nbits;
    logic [5:0]     word;
    bit             latch;
    bit             fs_same;
    bit             clr;
    bit             frame_after;
    logic [RW-1:0]  exp_ri;
    bit             exp_pend;
    bit             exp_err;
  } vec_t;

  vec_t tbl[18];

  // Reference behaviour kept in the bench's own terms.
  logic [NC-1:0][IW-1:0] m_shadow, m_active;
  logic [NC-1:0]         m_dirty;
  logic [5:0]            m_sreg;
  int                    m_cnt;
  bit                    m_pend, m_err;
  logic [RW-1:0]         sb[$];
  logic                  fs_seen = 1'b0;

  task automatic check(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_shadow = '0; m_active = '0; m_dirty = '0; m_sreg = '0;
    m_cnt = 0; m_pend = 1'b0; m_err = 1'b0;
    sb.delete();
  endtask

  task automatic cyc(input bit sh, input bit sd, input bit la, input bit fs, input bit clr);
    logic [RW-1:0] ri_before;
    logic [2:0]    ch;
    bit            valid;
    bus.cfg_shift = sh; bus.cfg_sdata = sd; bus.cfg_latch = la;
    bus.frame_start = fs; bus.err_clear = clr;
    if (sh) begin
      m_sreg = {m_sreg[4:0], sd};
      if (m_cnt < 7) m_cnt++;
    end
    ch    = m_sreg[5:3];
    valid = la && (m_cnt == 6) && (int'(ch) < NC);
    if (la) m_cnt = 0;
    if (fs) begin
      if (m_pend) begin
        for (int i = 0; i < NC; i++) if (m_dirty[i]) m_active[i] = m_shadow[i];
        m_dirty = '0;
        m_pend  = 1'b0;
      end
      sb.push_back(m_active);
    end
    if (valid) begin
      m_shadow[ch] = m_sreg[2:0];
      m_dirty[ch]  = 1'b1;
      m_pend       = 1'b1;
    end
    if (la && !valid) m_err = 1'b1;
    else if (clr)     m_err = 1'b0;
    ri_before = bus.read_index;
    @(posedge clk);
    #1;
    bus.cfg_shift = 0; bus.cfg_sdata = 0; bus.cfg_latch = 0;
    bus.frame_start = 0; bus.err_clear = 0;
    if (!fs) check("ri_hold", bus.read_index, ri_before);
    check("pending", RW'(bus.pending), RW'(m_pend));
    check("cfg_error", RW'(bus.cfg_error), RW'(m_err));
  endtask

  task automatic shift_bits(input logic [5:0] word, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, (i < 6) ? word[5-i] : 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #2;
    check({nm, "_ri"}, bus.read_index, '0);
    check({nm, "_pend"}, RW'(bus.pending), '0);
    check({nm, "_err"}, RW'(bus.cfg_error), '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // Every frame_start pushes the expected active set; the update must be visible one cycle later.
  always @(posedge clk) fs_seen <= bus.frame_start;

  always @(negedge clk) begin
    if (fs_seen) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow got=empty expected=entry");
      end else begin
        check("frame_ri", bus.read_index, sb.pop_front());
      end
    end
  end

  initial begin
    bus.cfg_sdata = 0; bus.cfg_shift = 0; bus.cfg_latch = 0;
    bus.frame_start = 0; bus.err_clear = 0;
    model_reset();

    tbl[0]  = '{"ch5_stage",    6, 6'b101011, 1, 0, 0, 0, 24'h000000, 1, 0};
    tbl[1]  = '{"ch5_apply",    0, 6'b000000, 0, 0, 0, 1, 24'h018000, 0, 0};
    tbl[2]  = '{"ch1_stage",    6, 6'b001111, 1, 0, 0, 0, 24'h018000, 1, 0};
    tbl[3]  = '{"ch2_stage",    6, 6'b010100, 1, 0, 0, 0, 24'h018000, 1, 0};
    tbl[4]  = '{"ch12_apply",   0, 6'b000000, 0, 0, 0, 1, 24'h018138, 0, 0};
    tbl[5]  = '{"short5",       5, 6'b110100, 1, 0, 0, 0, 24'h018138, 0, 1};
    tbl[6]  = '{"clr1",         0, 6'b000000, 0, 0, 1, 0, 24'h018138, 0, 0};
    tbl[7]  = '{"long7",        7, 6'b010101, 1, 0, 0, 0, 24'h018138, 0, 1};
    tbl[8]  = '{"clr2",         0, 6'b000000, 0, 0, 1, 0, 24'h018138, 0, 0};
    tbl[9]  = '{"ch0_stage",    6, 6'b000101, 1, 0, 0, 0, 24'h018138, 1, 0};
    tbl[10] = '{"ch3_latch_fs", 6, 6'b011010, 1, 1, 0, 0, 24'h01813D, 1, 0};
    tbl[11] = '{"ch3_apply",    0, 6'b000000, 0, 0, 0, 1, 24'h01853D, 0, 0};
    tbl[12] = '{"ch1_first",    6, 6'b001001, 1, 0, 0, 0, 24'h01853D, 1, 0};
    tbl[13] = '{"ch1_last",     6, 6'b001010, 1, 0, 0, 0, 24'h01853D, 1, 0};
    tbl[14] = '{"ch1_apply",    0, 6'b000000, 0, 0, 0, 1, 24'h018515, 0, 0};
    tbl[15] = '{"idle_err_clr", 0, 6'b000000, 1, 0, 1, 0, 24'h018515, 0, 1};
    tbl[16] = '{"clr3",         0, 6'b000000, 0, 0, 1, 0, 24'h018515, 0, 0};
    tbl[17] = '{"idle_frame",   0, 6'b000000, 0, 0, 0, 1, 24'h018515, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_ri", bus.read_index, '0);
    check("rst_pend", RW'(bus.pending), '0);
    check("rst_err", RW'(bus.cfg_error), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      shift_bits(tbl[k].word, tbl[k].nbits);
      if (tbl[k].latch || tbl[k].clr)
        cyc(1'b0, 1'b0, tbl[k].latch, tbl[k].fs_same, tbl[k].clr);
      if (tbl[k].frame_after) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check({tbl[k].name, "_ri"},   bus.read_index, tbl[k].exp_ri);
      check({tbl[k].name, "_pend"}, RW'(bus.pending), RW'(tbl[k].exp_pend));
      check({tbl[k].name, "_err"},  RW'(bus.cfg_error), RW'(tbl[k].exp_err));
    end

    // Last bit shifted in the latch cycle completes the command.
    shift_bits(6'b110001, 5);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("shl_pend", RW'(bus.pending), RW'(1));
    check("shl_err", RW'(bus.cfg_error), '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("shl_apply_ri", bus.read_index, 24'h058515);

    // Reset mid-command restarts the bit count.
    shift_bits(6'b111000, 3);
    do_reset("rst_cmd");
    shift_bits(6'b100110, 6);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_cmd_apply_ri", bus.read_index, 24'h006000);
    check("rst_cmd_err", RW'(bus.cfg_error), '0);

    // Reset while an update is pending discards it.
    shift_bits(6'b000110, 6);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_pend_staged", RW'(bus.pending), RW'(1));
    do_reset("rst_pend");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_pend_frame_ri", bus.read_index, '0);
    check("rst_pend_frame_pend", RW'(bus.pending), '0);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drain", RW'(sb.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_config_scheduler.md
# delay_config_scheduler

Controller that lets an external MCU program the per-channel read-index (delay) of every channel buffer in the beamformer over a 3-wire serial port. Commands are staged in shadow registers and are applied atomically to the active delay outputs only at an audio frame boundary. All channels therefore switch delay on the same sample. The block sits between the `uio_in` configuration pins and the `read_index` inputs of the `channel_buffer` instances.

## Interface
Parameters:
- `NUM_CHANNELS`, 8: number of channel buffers driven; range 2..8.
- `BUFFER_SIZE`, 8: channel buffer depth; power of two.
- `IDX_W`, `$clog2(BUFFER_SIZE)`: delay field width.
- `CH_W`, 3: channel field width.
- `CMD_W`, `CH_W+IDX_W`: command word length in bits.

Ports:
- `clk`  in  1  system clock; sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_sdata`  in  1  serial command bit, MSB first.
- `cfg_shift`  in  1  one-cycle strobe; samples `cfg_sdata` this cycle. Already synchronised to `clk`.
- `cfg_latch`  in  1  one-cycle strobe; ends the current command.
- `frame_start`  in  1  one-cycle pulse at each WS frame boundary.
- `err_clear`  in  1  clears `cfg_error`.
- `read_index`  out  `NUM_CHANNELS*IDX_W`  active delays, packed; channel 0 in the LSBs.
- `pending`  out  1  at least one staged update is not yet applied.
- `cfg_error`  out  1  sticky flag for a malformed command.

## Operation
- Receiver FSM, tracked by a bit counter `cnt` that saturates at `CMD_W+1`:
  - IDLE (`cnt`=0) -> SHIFT on `cfg_shift`.
  - SHIFT (0<`cnt`<`CMD_W`) -> FULL when `cnt` reaches `CMD_W`.
  - FULL -> OVER on a further `cfg_shift`.
  - OVER: shift register keeps the last `CMD_W` bits.
  - `cfg_latch` returns the FSM to IDLE from any state.
- Command word: `{channel[CH_W-1:0], delay[IDX_W-1:0]}`.
- `cfg_latch` in FULL with `channel < NUM_CHANNELS`:
  - `shadow[channel] <= delay`.
  - Set `dirty[channel]`.
  - `pending <= 1`.
- `cfg_latch` in IDLE, SHIFT or OVER, or with `channel >= NUM_CHANNELS`: `cfg_error <= 1`. Shadow and dirty are unchanged.
- `frame_start` with `pending`=1:
  - For each channel with `dirty` set, active <= shadow.
  - Clear all dirty bits; `pending <= 0`.
- `frame_start` with `pending`=0: no effect.
- A later latch to the same channel before `frame_start` overwrites the shadow value; last write wins.
- `err_clear`: `cfg_error <= 0`. A new error detected in the same cycle wins and leaves the flag at 1.
- `cfg_shift` and `cfg_latch` in the same cycle: the shift is applied first, then the latch evaluates the updated counter.
- `cfg_latch` and `frame_start` in the same cycle:
  - `frame_start` applies the previously staged values.
  - The new command lands in shadow with its dirty bit set.
  - `pending` ends at 1; the new value applies at the next frame.

## Timing
- Reset (async assert, sync release): `read_index`=0, all shadow=0, dirty=0, `pending`=0, `cfg_error`=0, FSM=IDLE.
- Reset asserted mid-command or mid-pending discards all staged state.
- `cfg_latch` in cycle N: shadow and `pending` are visible from N+1.
- `frame_start` in cycle M with `pending`=1: new `read_index` visible from M+1, and `pending`=0 from M+1.
- Minimum latch-to-apply is 2 cycles (latch at N, `frame_start` at N+1).
- `read_index` changes only in the cycle after a `frame_start`. It is registered, with no combinational path from any input.
- Error flag is visible the cycle after the offending `cfg_latch`.
- Throughput: one command per `CMD_W+1` cycles.

## Structure
- Shared package `beamformer_pkg` holds `NUMBER_OF_BITS`, `BUFFER_SIZE`, `IDX_W`, `CH_W`, `CMD_W` and the receiver state enum.
- Sub-module `cfg_serial_rx` contains the shift register, bit counter and FSM. Outputs: `cmd_valid`, `cmd_error`, `cmd_channel`, `cmd_delay`.
- The top level holds the shadow array, active array, dirty vector and pending/error logic.

## Test plan
- Reset, then shift `101011` (ch5, delay3) and latch, then `frame_start`:
  - `pending`=1 until the frame.
  - Afterwards, `read_index[17:15]`=3.
  - All other channels stay 0.
- Latch ch1=7 then ch2=4 with no `frame_start`:
  - `read_index` stays 0.
  - After one `frame_start`, both values appear in the same cycle.
- Shift 5 bits then latch -> `cfg_error`=1, no shadow change. `err_clear` -> 0.
- Shift 7 bits then latch -> `cfg_error`=1.
- Latch ch3=2 and `frame_start` in the same cycle:
  - `read_index` ch3 stays 0.
  - `pending` stays 1.
  - Next `frame_start` gives ch3=2.
- Latch ch0=6, pulse `rst_n` low before the frame, then `frame_start` -> `read_index`=0 and `pending`=0.
